// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg
//   Shared types for the pixel stream merger.
//   rgb_t          : packed {r,g,b} pixel at the default 8-bit component width
//   merger_state_t : frame sequencing states (LOAD -> STREAM -> DONE -> LOAD)
package pixel_stream_pkg;

    localparam int unsigned PIX_COLOR_W = 8;

    typedef struct packed {
        logic [PIX_COLOR_W-1:0] r;
        logic [PIX_COLOR_W-1:0] g;
        logic [PIX_COLOR_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } merger_state_t;

endpackage

// File: rtl/pixel_stream_merger_if.sv
// pixel_stream_merger_if
//   Bundles the per-core input handshakes and the merged output stream.
//   in_valid/in_ready/in_rgb : NUM_CORES pixel channels, {r,g,b} per core
//   out_valid/out_ready      : merged ready/valid stream
//   out_rgb/out_eol/out_sof  : merged pixel and its line/frame markers
//   slave  : merger side (consumes core pixels, produces the merged stream)
//   master : environment side (cores and downstream sink)
interface pixel_stream_merger_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned COLOR_W   = 8
);
    logic [NUM_CORES-1:0]           in_valid;
    logic [NUM_CORES-1:0]           in_ready;
    logic [NUM_CORES*3*COLOR_W-1:0] in_rgb;
    logic                           out_valid;
    logic                           out_ready;
    logic [3*COLOR_W-1:0]           out_rgb;
    logic                           out_eol;
    logic                           out_sof;

    modport slave (
        input  in_valid, in_rgb, out_ready,
        output in_ready, out_valid, out_rgb, out_eol, out_sof
    );

    modport master (
        output in_valid, in_rgb, out_ready,
        input  in_ready, out_valid, out_rgb, out_eol, out_sof
    );
endinterface

// File: rtl/pixel_fifo.sv
// pixel_fifo
//   Synchronous FIFO with a registered occupancy count and a zero-latency head.
//   aclk, aresetn : clock, synchronous active-low reset (empties the FIFO)
//   push/push_data: write request and data (ignored when full)
//   pop           : read request (ignored when empty)
//   head          : entry at the read pointer, valid whenever !empty
//   full, empty   : occupancy flags derived from the registered count
module pixel_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and count define contents.
    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pixel_stream_merger.sv
// pixel_stream_merger
//   Re-serialises pixels from NUM_CORES round-robin compute cores into one
//   raster-order ready/valid stream. Pixel k of a frame comes from core
//   k mod A (A = active cores); each core is buffered in its own pixel_fifo.
//   aclk, aresetn          : clock, synchronous active-low reset
//   pix (slave)            : per-core inputs and merged output stream
//   active_cores           : cores in use minus one, latched per frame
//   image_width/height     : frame size in pixels, latched per frame (0 -> 1)
//   frame_done             : one-cycle pulse after the last pixel of a frame
module pixel_stream_merger
    import pixel_stream_pkg::*;
#(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned COLOR_W    = 8,
    parameter int unsigned DIM_W      = 13
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    pixel_stream_merger_if.slave         pix,
    input  logic [$clog2(NUM_CORES)-1:0] active_cores,
    input  logic [DIM_W-1:0]             image_width,
    input  logic [DIM_W-1:0]             image_height,
    output logic                         frame_done
);
    localparam int unsigned CORE_W = $clog2(NUM_CORES);
    localparam int unsigned PIX_W  = 3 * COLOR_W;

    merger_state_t     state;
    logic [CORE_W-1:0] last_core_r;   // A_r - 1
    logic [CORE_W-1:0] cur;
    logic [DIM_W-1:0]  x_max_r;       // W_r - 1
    logic [DIM_W-1:0]  y_max_r;       // H_r - 1
    logic [DIM_W-1:0]  x;
    logic [DIM_W-1:0]  y;
    logic [CORE_W-1:0] cores_clamped;

    logic [NUM_CORES-1:0] full;
    logic [NUM_CORES-1:0] empty;
    logic [NUM_CORES-1:0] pop;
    logic [PIX_W-1:0]     head [NUM_CORES];
    logic                 hs;

    assign cores_clamped = ({1'b0, active_cores} >= (CORE_W+1)'(NUM_CORES))
                           ? CORE_W'(NUM_CORES - 1) : active_cores;

    assign pix.out_valid = (state == STREAM) && !empty[cur];
    assign pix.out_rgb   = pix.out_valid ? head[cur] : '0;
    assign pix.out_eol   = pix.out_valid && (x == x_max_r);
    assign pix.out_sof   = pix.out_valid && (x == '0) && (y == '0);
    assign frame_done    = (state == DONE);
    assign hs            = pix.out_valid && pix.out_ready;

    // in_ready depends only on registered state, never on out_ready.
    always_comb begin
        pix.in_ready = '0;
        pop          = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            pix.in_ready[i] = (CORE_W'(i) <= last_core_r) && !full[i] && (state != LOAD);
            pop[i]          = hs && (cur == CORE_W'(i));
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= LOAD;
            cur         <= '0;
            x           <= '0;
            y           <= '0;
            last_core_r <= '0;
            x_max_r     <= '0;
            y_max_r     <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    last_core_r <= cores_clamped;
                    x_max_r     <= (image_width  == '0) ? '0 : image_width  - DIM_W'(1);
                    y_max_r     <= (image_height == '0) ? '0 : image_height - DIM_W'(1);
                    cur         <= '0;
                    x           <= '0;
                    y           <= '0;
                    state       <= STREAM;
                end
                STREAM: begin
                    if (hs) begin
                        cur <= (cur == last_core_r) ? '0 : cur + CORE_W'(1);
                        if (x == x_max_r) begin
                            x <= '0;
                            if (y == y_max_r) begin
                                y     <= '0;
                                state <= DONE;
                            end else begin
                                y <= y + DIM_W'(1);
                            end
                        end else begin
                            x <= x + DIM_W'(1);
                        end
                    end
                end
                DONE:    state <= LOAD;
                default: state <= LOAD;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        pixel_fifo #(
            .WIDTH (PIX_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .aclk      (aclk),
            .aresetn   (aresetn),
            .push      (pix.in_valid[g] && pix.in_ready[g]),
            .push_data (pix.in_rgb[g*PIX_W +: PIX_W]),
            .pop       (pop[g]),
            .head      (head[g]),
            .full      (full[g]),
            .empty     (empty[g])
        );
    end

endmodule

// File: tb/tb_pixel_stream_merger.sv
// tb_pixel_stream_merger
//   Directed bench for pixel_stream_merger with a queue-based frame model
//   checked every cycle, plus literal expectations per scenario.
module tb_pixel_stream_merger;
    import pixel_stream_pkg::*;

    localparam int unsigned NC    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 8;
    localparam int unsigned DW    = 13;
    localparam int unsigned PW    = 3 * CW;

    typedef enum int {P_LOAD, P_STREAM, P_DONE} mphase_t;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [1:0]    active_cores;
    logic [DW-1:0] image_width;
    logic [DW-1:0] image_height;
    logic          frame_done;

    pixel_stream_merger_if #(.NUM_CORES(NC), .COLOR_W(CW)) pix ();

    pixel_stream_merger #(
        .NUM_CORES  (NC),
        .FIFO_DEPTH (DEPTH),
        .COLOR_W    (CW),
        .DIM_W      (DW)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .pix          (pix),
        .active_cores (active_cores),
        .image_width  (image_width),
        .image_height (image_height),
        .frame_done   (frame_done)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [PW-1:0] src [NC][$];
    logic [PW-1:0] mq  [NC][$];
    int            stall [NC];
    int            seq   [NC];
    logic          rdy_random = 1'b0;
    logic          rdy_level  = 1'b1;

    logic [PW-1:0] log_rgb [$];
    logic          log_eol [$];
    logic          log_sof [$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            last_hs_cyc = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    function automatic logic [PW-1:0] mkpix(input int core, input int tag);
        rgb_t p;
        p.r = 8'(core);
        p.g = 8'(seq[core]);
        p.b = 8'(tag);
        seq[core]++;
        return p;
    endfunction

    task automatic load_frame(input int a, input int w, input int h, input int tag);
        for (int k = 0; k < w * h; k++) src[k % a].push_back(mkpix(k % a, tag));
    endtask

    task automatic clear_log();
        log_rgb.delete();
        log_eol.delete();
        log_sof.delete();
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int target = done_cnt + n;
        int t = 0;
        while (done_cnt < target && t < budget) begin
            tick();
            t++;
        end
        chk(name, 64'(done_cnt >= target), 64'd1);
    endtask

    // Core sources and downstream sink.
    initial begin
        logic [NC-1:0] acc;
        for (int i = 0; i < NC; i++) begin
            stall[i] = 0;
            seq[i]   = 0;
        end
        pix.in_valid  = '0;
        pix.in_rgb    = '0;
        pix.out_ready = 1'b1;
        forever begin
            @(negedge aclk);
            acc = pix.in_valid & pix.in_ready;
            @(posedge aclk);
            #1;
            for (int i = 0; i < NC; i++) begin
                if (acc[i] && src[i].size() > 0) void'(src[i].pop_front());
                if (stall[i] > 0) stall[i]--;
                pix.in_valid[i] = (src[i].size() > 0) && (stall[i] == 0);
                pix.in_rgb[i*PW +: PW] = (src[i].size() > 0) ? src[i][0] : '0;
            end
            pix.out_ready = rdy_random ? 1'($urandom_range(0, 1)) : rdy_level;
        end
    end

    // Frame model: pixel k of a frame comes from core k mod A, in the order
    // that core delivered pixels; markers follow from k, W and H.
    initial begin
        bit            started = 0;
        mphase_t       phase   = P_LOAD;
        int            ma = 1, mw = 1, mh = 1, k = 0, c;
        logic [NC-1:0] exp_ready;
        logic          exp_valid, exp_eol, exp_sof, hs;
        forever begin
            @(negedge aclk);
            if (!started) begin
                if (aresetn === 1'b0) started = 1;
            end else begin
                c = k % ma;
                for (int i = 0; i < NC; i++)
                    exp_ready[i] = (phase != P_LOAD) && (i < ma) && (mq[i].size() < DEPTH);
                exp_valid = (phase == P_STREAM) && (mq[c].size() > 0);
                exp_eol   = exp_valid && ((k % mw) == mw - 1);
                exp_sof   = exp_valid && (k == 0);
                chk("in_ready",   64'(pix.in_ready),  64'(exp_ready));
                chk("out_valid",  64'(pix.out_valid), 64'(exp_valid));
                chk("out_eol",    64'(pix.out_eol),   64'(exp_eol));
                chk("out_sof",    64'(pix.out_sof),   64'(exp_sof));
                chk("frame_done", 64'(frame_done),    64'(phase == P_DONE));
                if (exp_valid) chk("out_rgb", 64'(pix.out_rgb), 64'(mq[c][0]));
                hs = exp_valid && pix.out_ready;
                if (frame_done === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (!aresetn) begin
                    for (int i = 0; i < NC; i++) mq[i].delete();
                    phase = P_LOAD;
                    k = 0;
                end else begin
                    if (hs) begin
                        log_rgb.push_back(pix.out_rgb);
                        log_eol.push_back(pix.out_eol);
                        log_sof.push_back(pix.out_sof);
                        last_hs_cyc = cyc;
                        void'(mq[c].pop_front());
                        k++;
                    end
                    for (int i = 0; i < NC; i++)
                        if (exp_ready[i] && pix.in_valid[i])
                            mq[i].push_back(pix.in_rgb[i*PW +: PW]);
                    case (phase)
                        P_LOAD: begin
                            ma = int'(active_cores) + 1;
                            if (ma > NC) ma = NC;
                            mw = (image_width  == 0) ? 1 : int'(image_width);
                            mh = (image_height == 0) ? 1 : int'(image_height);
                            k = 0;
                            phase = P_STREAM;
                        end
                        P_STREAM: if (hs && k == mw * mh) phase = P_DONE;
                        default:  phase = P_LOAD;
                    endcase
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_r1 [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        int exp_g1 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
        int exp_r4 [6] = '{0, 1, 2, 0, 1, 2};
        logic [PW-1:0] px;

        aresetn      = 1'b0;
        active_cores = 2'd1;
        image_width  = 13'd4;
        image_height = 13'd2;
        repeat (3) tick();

        // Reset state.
        chk("rst_in_ready",   64'(pix.in_ready),  64'd0);
        chk("rst_out_valid",  64'(pix.out_valid), 64'd0);
        chk("rst_out_rgb",    64'(pix.out_rgb),   64'd0);
        chk("rst_eol_sof",    64'({pix.out_eol, pix.out_sof}), 64'd0);
        chk("rst_frame_done", 64'(frame_done),    64'd0);
        aresetn = 1'b1;

        // 1: two cores, 4x2 frame, sink always ready.
        clear_log();
        load_frame(2, 4, 2, 1);
        wait_done(1, 200, "t1_done");
        chk("t1_count", 64'(log_rgb.size()), 64'd8);
        for (int i = 0; i < 8 && i < log_rgb.size(); i++) begin
            px = log_rgb[i];
            chk("t1_core", 64'(px[23:16]), 64'(exp_r1[i]));
            chk("t1_seq",  64'(px[15:8]),  64'(exp_g1[i]));
            chk("t1_eol",  64'(log_eol[i]), 64'(i == 3 || i == 7));
            chk("t1_sof",  64'(log_sof[i]), 64'(i == 0));
        end
        chk("t1_done_gap", 64'(done_cyc - last_hs_cyc), 64'd1);

        // 2: four cores, core 2 stalls; the others fill and back-pressure.
        active_cores = 2'd3;
        image_width  = 13'd8;
        image_height = 13'd3;
        stall[2] = 12;
        clear_log();
        load_frame(4, 8, 3, 2);
        repeat (8) tick();
        chk("t2_ready_stall", 64'(pix.in_ready),  64'b0100);
        chk("t2_out_stalled", 64'(pix.out_valid), 64'd0);
        chk("t2_pre_stall",   64'(log_rgb.size()), 64'd2);
        wait_done(1, 300, "t2_done");
        chk("t2_count", 64'(log_rgb.size()), 64'd24);
        for (int i = 0; i < log_rgb.size(); i++) begin
            px = log_rgb[i];
            chk("t2_order", 64'(px[23:16]), 64'(i % 4));
        end

        // 3: random sink back-pressure over three frames.
        active_cores = 2'd2;
        image_width  = 13'd5;
        image_height = 13'd2;
        rdy_random = 1'b1;
        for (int f = 0; f < 3; f++) begin
            clear_log();
            load_frame(3, 5, 2, 3 + f);
            wait_done(1, 400, "t3_done");
            chk("t3_count", 64'(log_rgb.size()), 64'd10);
        end
        rdy_random = 1'b0;
        rdy_level  = 1'b1;

        // 4: active_cores changes mid-frame.
        active_cores = 2'd1;
        image_width  = 13'd4;
        image_height = 13'd2;
        clear_log();
        load_frame(2, 4, 2, 6);
        repeat (3) tick();
        active_cores = 2'd2;
        chk("t4_core2_blocked", 64'(pix.in_ready[2]), 64'd0);
        wait_done(1, 200, "t4_done_a");
        chk("t4_count_a", 64'(log_rgb.size()), 64'd8);
        for (int i = 0; i < 8 && i < log_rgb.size(); i++) begin
            px = log_rgb[i];
            chk("t4_alt2", 64'(px[23:16]), 64'(exp_r1[i]));
        end
        image_width  = 13'd3;
        image_height = 13'd2;
        clear_log();
        load_frame(3, 3, 2, 7);
        wait_done(1, 200, "t4_done_b");
        chk("t4_count_b", 64'(log_rgb.size()), 64'd6);
        for (int i = 0; i < 6 && i < log_rgb.size(); i++) begin
            px = log_rgb[i];
            chk("t4_cyc3", 64'(px[23:16]), 64'(exp_r4[i]));
        end

        // 5: zero width -> one-pixel frames, every pixel is SOF and EOL.
        active_cores = 2'd1;
        image_width  = 13'd0;
        image_height = 13'd1;
        clear_log();
        for (int i = 0; i < 3; i++) src[0].push_back(mkpix(0, 8));
        wait_done(3, 100, "t5_done");
        chk("t5_count", 64'(log_rgb.size()), 64'd3);
        for (int i = 0; i < 3 && i < log_rgb.size(); i++) begin
            chk("t5_eol", 64'(log_eol[i]), 64'd1);
            chk("t5_sof", 64'(log_sof[i]), 64'd1);
        end
        chk("t5_done_gap", 64'(done_cyc - last_hs_cyc), 64'd1);

        // 6: one-cycle reset mid-frame with every FIFO full.
        active_cores = 2'd3;
        image_width  = 13'd8;
        image_height = 13'd3;
        rdy_level = 1'b0;
        load_frame(4, 8, 3, 9);
        repeat (10) tick();
        chk("t6_all_full", 64'(pix.in_ready),  64'd0);
        chk("t6_held",     64'(pix.out_valid), 64'd1);
        active_cores = 2'd1;
        image_width  = 13'd2;
        image_height = 13'd2;
        aresetn = 1'b0;
        for (int i = 0; i < NC; i++) src[i].delete();
        tick();
        chk("t6_rst_in_ready",   64'(pix.in_ready),  64'd0);
        chk("t6_rst_out_valid",  64'(pix.out_valid), 64'd0);
        chk("t6_rst_out_rgb",    64'(pix.out_rgb),   64'd0);
        chk("t6_rst_eol_sof",    64'({pix.out_eol, pix.out_sof}), 64'd0);
        chk("t6_rst_frame_done", 64'(frame_done),    64'd0);
        aresetn   = 1'b1;
        rdy_level = 1'b1;
        clear_log();
        load_frame(2, 2, 2, 10);
        wait_done(1, 200, "t6_done");
        chk("t6_count", 64'(log_rgb.size()), 64'd4);
        if (log_rgb.size() > 0) begin
            px = log_rgb[0];
            chk("t6_first_core", 64'(px[23:16]), 64'd0);
            chk("t6_first_tag",  64'(px[7:0]),   64'd10);
            chk("t6_first_sof",  64'(log_sof[0]), 64'd1);
        end

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
